// File: rtl/seq_divider_if.sv
// Handshake and result bundle between the execute-stage control unit and seq_divider.
// The control unit is the master; the divider is the slave.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             div_end;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output div_start, div_signed, dividend, divisor,
    input  busy, div_end, div_by_zero, hi, lo
  );

  modport slave (
    input  div_start, div_signed, dividend, divisor,
    output busy, div_end, div_by_zero, hi, lo
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring DIV/DIVU for HI/LO: WIDTH+1 cycles start-to-div_end; starts while busy are dropped.
// SEQ_DIVIDER_EARLY_TERM_EN: finish at the start edge when |dividend| < |divisor|.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd, dvs, quo, rem;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg;
  logic             busy, div_end, div_by_zero;
  logic [WIDTH-1:0] hi, lo;

  logic             a_neg, b_neg, div_zero, early, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   trial;
  logic             fits;

  always_comb begin
    a_neg    = bus.div_signed & bus.dividend[WIDTH-1];
    b_neg    = bus.div_signed & bus.divisor[WIDTH-1];
    mag_a    = a_neg ? -bus.dividend : bus.dividend;
    mag_b    = b_neg ? -bus.divisor : bus.divisor;
    div_zero = (bus.divisor == '0);
    accept   = (state == IDLE) && bus.div_start;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
    early    = !div_zero && (mag_a < mag_b);
`else
    early    = 1'b0;
`endif
    // Partial remainder with the next dividend bit shifted in.
    trial    = {rem, dvd[WIDTH-1]};
    fits     = (trial >= {1'b0, dvs});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !div_zero && !early) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      busy        <= 1'b0;
      div_end     <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      div_end     <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              div_end     <= 1'b1;
              div_by_zero <= 1'b1;
            end else if (early) begin
              hi      <= bus.dividend;
              lo      <= '0;
              div_end <= 1'b1;
            end else begin
              dvd   <= mag_a;
              dvs   <= mag_b;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              quo   <= '0;
              rem   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          // The restored remainder is always below the divisor, so WIDTH bits hold it.
          rem <= fits ? WIDTH'(trial - {1'b0, dvs}) : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          lo      <= q_neg ? -quo : quo;
          hi      <= r_neg ? -rem : rem;
          div_end <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.div_end     = div_end;
  assign bus.div_by_zero = div_by_zero;
  assign bus.hi          = hi;
  assign bus.lo          = lo;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operations push expected hi/lo/flag/latency,
// a negedge monitor pops on every div_end and compares.
module tb_seq_divider;
  localparam int W = 32;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
  localparam int EARLY_LAT = 0;
`else
  localparam int EARLY_LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   op_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.div_end) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_div_end actual=1 required=0 cyc=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("op%0d_lo", mon_e.id), 64'(bus.lo), 64'(mon_e.lo));
        check($sformatf("op%0d_hi", mon_e.id), 64'(bus.hi), 64'(mon_e.hi));
        check($sformatf("op%0d_dbz", mon_e.id), 64'(bus.div_by_zero), 64'(mon_e.dbz));
        check($sformatf("op%0d_latency", mon_e.id), 64'(cyc - mon_e.start), 64'(mon_e.lat));
      end
    end
  end

  // Called at a negedge just before the start edge.
  task automatic push(logic [31:0] exp_hi, logic [31:0] exp_lo, logic dbz, int lat);
    push_e.id    = op_id;
    push_e.hi    = exp_hi;
    push_e.lo    = exp_lo;
    push_e.dbz   = dbz;
    push_e.lat   = lat;
    push_e.start = cyc + 1;
    sb.push_back(push_e);
    op_id++;
  endtask

  task automatic drive(bit sgn, logic [31:0] a, logic [31:0] b);
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_start  = 1'b1;
  endtask

  task automatic scramble();
    bus.div_start  = 1'b0;
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
    bus.div_signed = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_div_end actual=pending%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(bit sgn, logic [31:0] a, logic [31:0] b,
                     logic [31:0] exp_hi, logic [31:0] exp_lo, logic dbz, int lat);
    @(negedge clk);
    drive(sgn, a, b);
    push(exp_hi, exp_lo, dbz, lat);
    @(negedge clk);
    scramble();
    drain();
  endtask

  int nb;

  initial begin
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_div_end", 64'(bus.div_end), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7 with busy-length check and an ignored mid-CALC start.
    drive(1'b1, 32'd100, 32'd7);
    push(32'd2, 32'd14, 1'b0, 33);
    @(negedge clk);
    scramble();
    nb = 0;
    for (int i = 0; i < 60 && bus.busy; i++) begin
      nb++;
      if (i == 5) drive(1'b0, 32'd1, 32'd1);
      if (i == 6) bus.div_start = 1'b0;
      @(negedge clk);
    end
    check("busy_cycles", 64'(nb), 64'd33);
    drain();
    repeat (3) @(negedge clk);

    run(1'b0, 32'd5, 32'd0, 32'd2, 32'd14, 1'b1, 0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
    run(1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 1'b0, 33);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
    run(1'b0, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 1'b0, 33);
    run(1'b1, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, EARLY_LAT);
    run(1'b1, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 32'd0, 1'b0, EARLY_LAT);

    // Abort 100 / 7 ten cycles in; no div_end may follow.
    @(negedge clk);
    drive(1'b1, 32'd100, 32'd7);
    @(negedge clk);
    scramble();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_div_end", 64'(bus.div_end), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_busy_after", 64'(bus.busy), 64'd0);

    run(1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
